ram_mem_bridge: RTL

- Bridges the picorv32 native memory interface (mem_valid/mem_ready handshake with byte strobes) to the word-wide simple dual-port RAM used for firmware/data storage.
- The RAM has no byte enables. Partial-word stores are therefore done as read-modify-write (RMW) inside this block.
- Sits directly upstream of the RAM. It drives the RAM's write and read ports and consumes its one-cycle-latency registered read data.

---
 rtl/ram_mem_bridge_pkg.sv | 26 ++
 rtl/ram_mem_bridge_byte_merge.sv | 27 ++
 rtl/ram_mem_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_mem_bridge_pkg.sv
// Shared types and constants for the picorv32-to-RAM bridge.
package ram_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_RD  = 2'd0,
    KIND_WR  = 2'd1,
    KIND_RMW = 2'd2
  } kind_e;

  localparam int AWIDTH_DEFAULT = 14;
  localparam int DWIDTH_DEFAULT = 32;

  function automatic int swidth_of(input int dwidth);
    return dwidth / 8;
  endfunction

  localparam int SWIDTH_DEFAULT = swidth_of(DWIDTH_DEFAULT);
  localparam logic [SWIDTH_DEFAULT-1:0] FULL_STROBE = {SWIDTH_DEFAULT{1'b1}};

endpackage

// File: rtl/ram_mem_bridge_byte_merge.sv
// Combinational byte merge: strobed bytes from new_word, the rest from old_word.
module ram_mem_bridge_byte_merge
  import ram_mem_bridge_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic [DWIDTH-1:0]           old_word,
  input  logic [DWIDTH-1:0]           new_word,
  input  logic [swidth_of(DWIDTH)-1:0] strobe,
  output logic [DWIDTH-1:0]           merged
);

  localparam int SWIDTH = swidth_of(DWIDTH);

  // select each byte lane independently
  always_comb begin
    merged = old_word;
    for (int i = 0; i < SWIDTH; i++) begin
      if (strobe[i]) begin
        merged[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        merged[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ram_mem_bridge.sv
// picorv32 native memory interface to word-wide dual-port RAM, partial stores via RMW.
// Optional request counters: define RAM_MEM_BRIDGE_STAT_EN.
module ram_mem_bridge
  import ram_mem_bridge_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEFAULT,
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          mem_valid,
  input  logic                          mem_instr,
  output logic                          mem_ready,
  input  logic [31:0]                   mem_addr,
  input  logic [DWIDTH-1:0]             mem_wdata,
  input  logic [swidth_of(DWIDTH)-1:0]  mem_wstrb,
  output logic [DWIDTH-1:0]             mem_rdata,
  output logic [DWIDTH-1:0]             ram_di,
  output logic                          ram_wren,
  output logic [AWIDTH-1:0]             ram_wraddr,
  output logic                          ram_rden,
  output logic [AWIDTH-1:0]             ram_rdaddr,
  input  logic [DWIDTH-1:0]             ram_do
`ifdef RAM_MEM_BRIDGE_STAT_EN
  ,
  output logic [31:0]                   stat_rd,
  output logic [31:0]                   stat_wr,
  output logic [31:0]                   stat_rmw
`endif
);

  localparam int SWIDTH = swidth_of(DWIDTH);
  localparam logic [SWIDTH-1:0] ALL_ONES  = {SWIDTH{1'b1}};
  localparam logic [SWIDTH-1:0] NO_STROBE = {SWIDTH{1'b0}};

  state_e              state_r;
  state_e              next_state_s;
  logic [AWIDTH-1:0]   word_addr_s;
  logic [AWIDTH-1:0]   addr_r;
  logic [DWIDTH-1:0]   wdata_r;
  logic [SWIDTH-1:0]   wstrb_r;
  logic [DWIDTH-1:0]   rdata_r;
  logic                ready_r;
  logic                latch_s;
  logic                wren_s;
  logic                rden_s;
  logic [AWIDTH-1:0]   wraddr_s;
  logic [DWIDTH-1:0]   di_s;
  logic [DWIDTH-1:0]   merged_s;
  logic                full_s;
  logic                unused_s;

  assign word_addr_s = mem_addr[AWIDTH+1:2];
  assign full_s      = (mem_wstrb == ALL_ONES);
  // address bits outside the word field are decoded upstream
  assign unused_s    = ^{mem_instr, mem_addr[31:AWIDTH+2], mem_addr[1:0]};

  ram_mem_bridge_byte_merge #(
    .DWIDTH (DWIDTH)
  ) u_merge (
    .old_word (ram_do),
    .new_word (wdata_r),
    .strobe   (wstrb_r),
    .merged   (merged_s)
  );

  // next-state and RAM port control
  always_comb begin
    next_state_s = state_r;
    latch_s      = 1'b0;
    wren_s       = 1'b0;
    rden_s       = 1'b0;
    wraddr_s     = word_addr_s;
    di_s         = mem_wdata;
    case (state_r)
      IDLE: begin
        if (mem_valid) begin
          if (full_s) begin
            wren_s       = 1'b1;
            next_state_s = DONE;
          end else begin
            rden_s       = 1'b1;
            latch_s      = 1'b1;
            next_state_s = RD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RD: begin
        if (wstrb_r != NO_STROBE) begin
          wren_s   = 1'b1;
          wraddr_s = addr_r;
          di_s     = merged_s;
        end else begin
          wren_s   = 1'b0;
        end
        next_state_s = DONE;
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // state, request latches and registered CPU-side outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
      addr_r  <= {AWIDTH{1'b0}};
      wdata_r <= {DWIDTH{1'b0}};
      wstrb_r <= NO_STROBE;
      rdata_r <= {DWIDTH{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == DONE);
      if (latch_s) begin
        addr_r  <= word_addr_s;
        wdata_r <= mem_wdata;
        wstrb_r <= mem_wstrb;
      end
      if ((state_r == RD) && (wstrb_r == NO_STROBE)) begin
        rdata_r <= ram_do;
      end
    end
  end

  assign mem_ready  = ready_r;
  assign mem_rdata  = rdata_r;
  // enables are gated so nothing reaches the RAM on a reset cycle
  assign ram_wren   = wren_s & resetn;
  assign ram_rden   = rden_s & resetn;
  assign ram_wraddr = wraddr_s;
  assign ram_rdaddr = word_addr_s;
  assign ram_di     = di_s;

`ifdef RAM_MEM_BRIDGE_STAT_EN
  kind_e       kind_r;
  logic [31:0] stat_rd_r;
  logic [31:0] stat_wr_r;
  logic [31:0] stat_rmw_r;

  // classify the request on acceptance, count it when it completes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      kind_r     <= KIND_RD;
      stat_rd_r  <= 32'd0;
      stat_wr_r  <= 32'd0;
      stat_rmw_r <= 32'd0;
    end else begin
      if ((state_r == IDLE) && mem_valid) begin
        if (full_s) begin
          kind_r <= KIND_WR;
        end else if (mem_wstrb == NO_STROBE) begin
          kind_r <= KIND_RD;
        end else begin
          kind_r <= KIND_RMW;
        end
      end
      if (state_r == DONE) begin
        case (kind_r)
          KIND_RD:  stat_rd_r  <= stat_rd_r + 32'd1;
          KIND_WR:  stat_wr_r  <= stat_wr_r + 32'd1;
          KIND_RMW: stat_rmw_r <= stat_rmw_r + 32'd1;
          default:  stat_rd_r  <= stat_rd_r;
        endcase
      end
    end
  end

  assign stat_rd  = stat_rd_r;
  assign stat_wr  = stat_wr_r;
  assign stat_rmw = stat_rmw_r;
`endif

endmodule
